// File: rtl/apb_cmd_master.sv
// APB command master: a small command FIFO feeding an APB3/4 requester with a wait-state timeout.
// state  | meaning
// IDLE   | bus idle, waiting for a queued command
// SETUP  | psel high, penable low, popped command on the bus
// ACCESS | psel and penable high, waiting for pready or timeout
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_write_i,
    input  logic [ADDR_W-1:0]          cmd_addr_i,
    input  logic [DATA_W-1:0]          cmd_wdata_i,
    input  logic [DATA_W/8-1:0]        cmd_strb_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       psel_o,
    output logic                       penable_o,
    output logic                       pwrite_o,
    output logic [ADDR_W-1:0]          paddr_o,
    output logic [DATA_W-1:0]          pwdata_o,
    output logic [DATA_W/8-1:0]        pstrb_o,
    input  logic                       pready_i,
    input  logic                       pslverr_i,
    input  logic [DATA_W-1:0]          prdata_i,
    output logic                       rsp_valid_o,
    output logic                       rsp_write_o,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic                       rsp_timeout_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 1 + ADDR_W + DATA_W + SW;
    localparam logic [PW:0]   LVL_FULL = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state, state_next;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [CW-1:0]   tmo_cnt;
    logic            push, pop, complete, abort;
    logic            head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic [SW-1:0]   head_strb;

    assign cmd_ready_o = (count != LVL_FULL);
    assign level_o     = count;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign psel_o      = (state != IDLE);
    assign penable_o   = (state == ACCESS);
    assign {head_write, head_addr, head_wdata, head_strb} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i};
    end

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // pready has priority over the terminal count on the same edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (pready_i)                complete = 1'b1;
                else if (tmo_cnt == TMO_LAST) abort   = 1'b1;
                if (complete || abort) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          tmo_cnt <= '0;
        else if (pop)                       tmo_cnt <= '0;
        else if (state == ACCESS && !pready_i) tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_write_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            if (pop) begin
                pwrite_o <= head_write;
                paddr_o  <= head_addr;
                pwdata_o <= head_wdata;
                pstrb_o  <= head_write ? head_strb : '0;
            end
            rsp_valid_o   <= complete | abort;
            rsp_write_o   <= (complete | abort) & pwrite_o;
            rsp_rdata_o   <= (complete && !pwrite_o) ? prdata_i : '0;
            rsp_err_o     <= abort | (complete & pslverr_i);
            rsp_timeout_o <= abort;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed vector table, hand sequences and random traffic
// against a transaction-level model (pending-command queue plus APB phase/response rules).
module tb_apb_cmd_master;
    localparam int ADDR_W = 32, DATA_W = 32, DEPTH = 4, TIMEOUT = 16;
    localparam int SW = DATA_W / 8, LW = $clog2(DEPTH) + 1;
    localparam logic [1:0] PH_IDLE = 2'b00, PH_SETUP = 2'b10, PH_ACCESS = 2'b11;

    logic clk = 1'b0, reset = 1'b1;
    logic cmd_valid_i = 0, cmd_ready_o, cmd_write_i = 0;
    logic [ADDR_W-1:0] cmd_addr_i = '0, paddr_o;
    logic [DATA_W-1:0] cmd_wdata_i = '0, pwdata_o, prdata_i = '0, rsp_rdata_o;
    logic [SW-1:0] cmd_strb_i = '0, pstrb_o;
    logic [LW-1:0] level_o;
    logic psel_o, penable_o, pwrite_o, pready_i = 0, pslverr_i = 0;
    logic rsp_valid_o, rsp_write_o, rsp_err_o, rsp_timeout_o;

    always #5 clk = ~clk;

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i), .level_o(level_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .prdata_i(prdata_i), .rsp_valid_o(rsp_valid_o), .rsp_write_o(rsp_write_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o)
    );

    typedef struct {
        logic w; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; logic [SW-1:0] strb;
    } cmd_t;
    typedef struct {
        logic w; logic [DATA_W-1:0] rdata; logic err; logic tmo;
    } rsp_t;
    typedef struct {
        logic w; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; int waits;
        logic slverr; logic [31:0] prdata; logic exp_err; logic exp_tmo; logic [31:0] exp_rdata; int exp_pen;
    } vec_t;

    cmd_t cmd_q[$];
    cmd_t cur;
    int   wait_cnt = 0;
    int   tests = 0, fails = 0;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cmd_q.delete();
        wait_cnt = 0;
    endtask

    // One clock: predict what the coming edge must do, let it happen, then compare.
    task automatic tick();
        int q_before;
        logic pushed, done;
        logic [1:0] ph, exp_ph;
        rsp_t r;
        cmd_t c;
        q_before = cmd_q.size();
        pushed = cmd_valid_i & cmd_ready_o;
        ph = {psel_o, penable_o};
        done = 1'b0;
        r.w = 1'b0; r.rdata = '0; r.err = 1'b0; r.tmo = 1'b0;
        case (ph)
            PH_SETUP: begin
                exp_ph = PH_ACCESS;
                wait_cnt = 0;
            end
            PH_ACCESS: begin
                if (pready_i) begin
                    done = 1'b1; r.w = cur.w; r.rdata = cur.w ? '0 : prdata_i; r.err = pslverr_i;
                end else begin
                    wait_cnt++;
                    if (wait_cnt >= TIMEOUT) begin
                        done = 1'b1; r.w = cur.w; r.err = 1'b1; r.tmo = 1'b1;
                    end
                end
                if (!done) exp_ph = PH_ACCESS;
                else       exp_ph = (q_before > 0) ? PH_SETUP : PH_IDLE;
            end
            default: exp_ph = (q_before > 0) ? PH_SETUP : PH_IDLE;
        endcase
        if (pushed) begin
            c.w = cmd_write_i; c.addr = cmd_addr_i; c.wdata = cmd_wdata_i; c.strb = cmd_strb_i;
            cmd_q.push_back(c);
        end
        @(posedge clk);
        #1;
        chk("bus_phase", {psel_o, penable_o}, exp_ph);
        if (exp_ph == PH_SETUP && cmd_q.size() > 0) begin
            cur = cmd_q.pop_front();
            chk("setup_paddr", paddr_o, cur.addr);
            chk("setup_pwrite", pwrite_o, cur.w);
            chk("setup_pwdata", pwdata_o, cur.wdata);
            chk("setup_pstrb", pstrb_o, cur.w ? cur.strb : '0);
        end else if (exp_ph == PH_ACCESS) begin
            chk("access_paddr_stable", paddr_o, cur.addr);
            chk("access_pwrite_stable", pwrite_o, cur.w);
            chk("access_pwdata_stable", pwdata_o, cur.wdata);
            chk("access_pstrb_stable", pstrb_o, cur.w ? cur.strb : '0);
        end
        chk("rsp_valid", rsp_valid_o, done);
        if (done && rsp_valid_o) begin
            chk("rsp_write", rsp_write_o, r.w);
            chk("rsp_rdata", rsp_rdata_o, r.rdata);
            chk("rsp_err", rsp_err_o, r.err);
            chk("rsp_timeout", rsp_timeout_o, r.tmo);
        end
        chk("level", level_o, cmd_q.size());
        chk("cmd_ready", cmd_ready_o, cmd_q.size() < DEPTH);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int acc;
        logic got;
        v = vecs[i];
        cmd_write_i = v.w; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata; cmd_strb_i = v.strb;
        cmd_valid_i = 1'b1; pready_i = 1'b0; pslverr_i = 1'b0;
        tick();
        cmd_valid_i = 1'b0;
        acc = 0;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            if (rsp_valid_o) begin
                got = 1'b1;
                chk($sformatf("vec%0d_write", i), rsp_write_o, v.w);
                chk($sformatf("vec%0d_err", i), rsp_err_o, v.exp_err);
                chk($sformatf("vec%0d_timeout", i), rsp_timeout_o, v.exp_tmo);
                chk($sformatf("vec%0d_rdata", i), rsp_rdata_o, v.exp_rdata);
            end else begin
                if (psel_o && penable_o) begin
                    pready_i = (acc == v.waits); pslverr_i = v.slverr; prdata_i = v.prdata;
                    acc++;
                end else begin
                    pready_i = 1'b0; pslverr_i = 1'b0;
                end
                tick();
            end
        end
        chk($sformatf("vec%0d_done", i), got, 1'b1);
        chk($sformatf("vec%0d_penable_cycles", i), acc, v.exp_pen);
        pready_i = 1'b0; pslverr_i = 1'b0;
    endtask

    task automatic drain();
        cmd_valid_i = 1'b0;
        pready_i = 1'b1;
        pslverr_i = 1'b0;
        for (int n = 0; n < 80 && (cmd_q.size() > 0 || psel_o); n++) tick();
        chk("drain_idle", {psel_o, cmd_q.size() == 0}, 2'b01);
        pready_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic full;
        logic started;
        int   rsp_cnt;
        int   stall;

        //          w     addr    wdata         strb  waits err   prdata        e_err e_tmo e_rdata      e_pen
        vecs[0] = '{1'b1, 32'h10, 32'hA5,       4'hF, 0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1};
        vecs[1] = '{1'b0, 32'h20, 32'h0,        4'hF, 3,    1'b0, 32'h1234,     1'b0, 1'b0, 32'h1234,    4};
        vecs[2] = '{1'b1, 32'h30, 32'h5A5A,     4'h3, 2,    1'b1, 32'h0,        1'b1, 1'b0, 32'h0,       3};
        vecs[3] = '{1'b0, 32'h40, 32'h0,        4'h0, 100,  1'b0, 32'hDEAD,     1'b1, 1'b1, 32'h0,       16};
        vecs[4] = '{1'b0, 32'h44, 32'h0,        4'h5, 15,   1'b0, 32'hBEEF,     1'b0, 1'b0, 32'hBEEF,    16};
        vecs[5] = '{1'b0, 32'h48, 32'h0,        4'h0, 1,    1'b1, 32'h77,       1'b1, 1'b0, 32'h77,      2};
        vecs[6] = '{1'b1, 32'h4C, 32'hFFFF0000, 4'hC, 100,  1'b0, 32'h0,        1'b1, 1'b1, 32'h0,       16};

        #12;
        chk("rst_psel", psel_o, 1'b0);
        chk("rst_penable", penable_o, 1'b0);
        chk("rst_apb_regs", {pwrite_o, paddr_o, pwdata_o, pstrb_o}, '0);
        chk("rst_rsp", {rsp_valid_o, rsp_write_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}, '0);
        chk("rst_level", level_o, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("post_rst_ready", cmd_ready_o, 1'b1);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Fill the FIFO behind a stalled transfer, hold an extra command, then release.
        pready_i = 1'b0;
        full = 1'b0;
        for (int n = 0; n < 12 && !full; n++) begin
            cmd_valid_i = 1'b1; cmd_write_i = 1'b1;
            cmd_addr_i = 32'h200 + 32'(n); cmd_wdata_i = 32'(n); cmd_strb_i = 4'hF;
            tick();
            if (!cmd_ready_o) full = 1'b1;
        end
        chk("fill_reached", full, 1'b1);
        chk("fill_level", level_o, DEPTH);
        chk("fill_ready", cmd_ready_o, 1'b0);
        cmd_addr_i = 32'h2FF; cmd_write_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("held_level", level_o, DEPTH);
        end
        pready_i = 1'b1;
        tick();
        tick();
        cmd_valid_i = 1'b0;
        drain();

        // Back-to-back writes, first one errored; psel must not drop between them.
        pready_i = 1'b1; pslverr_i = 1'b1;
        started = 1'b0; rsp_cnt = 0;
        for (int n = 0; n < 30 && rsp_cnt < 3; n++) begin
            cmd_valid_i = (n < 3); cmd_write_i = 1'b1;
            cmd_addr_i = 32'h100 + 32'(n); cmd_wdata_i = 32'hC0DE0000 + 32'(n); cmd_strb_i = 4'hF;
            tick();
            if (rsp_valid_o) begin
                rsp_cnt++;
                if (rsp_cnt == 1) begin
                    chk("b2b_first_err", rsp_err_o, 1'b1);
                    chk("b2b_first_timeout", rsp_timeout_o, 1'b0);
                end
            end
            if (psel_o) started = 1'b1;
            if (started && rsp_cnt < 3) chk("b2b_psel_held", psel_o, 1'b1);
            pslverr_i = (rsp_cnt == 0);
        end
        chk("b2b_done", rsp_cnt, 3);
        drain();

        // Random traffic with occasional long stalls to provoke timeouts.
        stall = 0;
        for (int n = 0; n < 1500; n++) begin
            cmd_valid_i = 1'($urandom_range(0, 1));
            cmd_write_i = 1'($urandom_range(0, 1));
            cmd_addr_i  = $urandom;
            cmd_wdata_i = $urandom;
            cmd_strb_i  = 4'($urandom_range(0, 15));
            if (stall == 0 && $urandom_range(0, 99) < 2) stall = 20;
            if (stall > 0) begin
                pready_i = 1'b0;
                stall--;
            end else begin
                pready_i = ($urandom_range(0, 2) != 0);
            end
            pslverr_i = ($urandom_range(0, 7) == 0);
            prdata_i  = $urandom;
            tick();
        end
        drain();

        // Reset in the middle of ACCESS with two commands still queued.
        pready_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cmd_valid_i = 1'b1; cmd_write_i = 1'b0;
            cmd_addr_i = 32'h300 + 32'(n); cmd_strb_i = 4'h0;
            tick();
        end
        cmd_valid_i = 1'b0;
        chk("pre_rst_access", {psel_o, penable_o}, PH_ACCESS);
        chk("pre_rst_level", level_o, 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_psel", psel_o, 1'b0);
        chk("mid_rst_penable", penable_o, 1'b0);
        chk("mid_rst_level", level_o, 0);
        chk("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
        model_reset();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        pready_i = 1'b1;
        for (int n = 0; n < 6; n++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
